// File: rtl/p_sum_accum_scratch.sv
// Partial-sum scratchpad: 3-edge accumulate RMW pipeline, read port with clear-on-read, bulk-clear FSM.
// Define PSUM_SAT_EN for saturating adds plus the sticky sat_flag_o output; the default build wraps.
module p_sum_accum_scratch #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int IN_WIDTH      = 16,
  parameter int SCRATCH_WIDTH = 24
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             acc_valid_i,
  output logic                             acc_ready_o,
  input  logic                             acc_init_i,
  input  logic [ADDR_LEN-1:0]              acc_addr_i,
  input  logic signed [IN_WIDTH-1:0]       acc_din_i,
  input  logic                             rd_en_i,
  input  logic                             rd_clear_i,
  input  logic [ADDR_LEN-1:0]              rd_addr_i,
  output logic                             rd_valid_o,
  output logic signed [SCRATCH_WIDTH-1:0]  rd_data_o,
  input  logic                             clr_start_i,
  output logic                             busy_o
`ifdef PSUM_SAT_EN
  ,
  output logic                             sat_flag_o
`endif
);
  localparam int AW = ADDR_LEN;
  localparam int SW = SCRATCH_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_e;

  state_e                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  busy_q;
  logic signed [SW-1:0]  mem_q [SCRATCH_DEPTH];

  logic                  s1_vld_q, s1_init_q;
  logic [AW-1:0]         s1_addr_q;
  logic signed [SW-1:0]  s1_din_q;
  logic                  s2_vld_q, s2_init_q;
  logic [AW-1:0]         s2_addr_q;
  logic signed [SW-1:0]  s2_din_q, s2_old_q;
  logic                  rd_valid_q;
  logic signed [SW-1:0]  rd_data_q;

  logic                  acc_fire, rd_fire, rd_clr_en, commit_en, clr_done;
  logic signed [SW-1:0]  mem_wr_d, s2_old_d, rd_data_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < SCRATCH_DEPTH;
  endfunction

  // A clear request pre-empts any accumulate or read offered in the same cycle.
  assign acc_ready_o = (state_q == IDLE) & ~clr_start_i;
  assign acc_fire    = acc_valid_i & acc_ready_o;
  assign rd_fire     = rd_en_i & acc_ready_o;
  assign rd_clr_en   = rd_fire & rd_clear_i & in_range(rd_addr_i);
  assign commit_en   = s2_vld_q & in_range(s2_addr_q);
  assign clr_done    = (state_q == CLEAR) && (cnt_q == AW'(SCRATCH_DEPTH - 1));
  assign busy_o      = busy_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

`ifdef PSUM_SAT_EN
  logic signed [SW:0] sum_wide;
  logic               ovf;
  logic               sat_q;

  assign sum_wide = (SW+1)'(s2_old_q) + (SW+1)'(s2_din_q);
  assign ovf      = sum_wide[SW] ^ sum_wide[SW-1];

  always_comb begin
    mem_wr_d = sum_wide[SW-1:0];
    if (s2_init_q)
      mem_wr_d = s2_din_q;
    else if (ovf)
      mem_wr_d = sum_wide[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      sat_q <= 1'b0;
    else if (clr_done)
      sat_q <= 1'b0;
    else if (commit_en && !s2_init_q && ovf)
      sat_q <= 1'b1;
  end

  assign sat_flag_o = sat_q;
`else
  assign mem_wr_d = s2_init_q ? s2_din_q : s2_old_q + s2_din_q;
`endif

  // S1 lookup sees the entry as it stands after this edge: clear-on-read beats the S2 commit.
  always_comb begin
    s2_old_d = '0;
    if (in_range(s1_addr_q)) begin
      if (rd_clr_en && rd_addr_i == s1_addr_q)
        s2_old_d = '0;
      else if (commit_en && s2_addr_q == s1_addr_q)
        s2_old_d = mem_wr_d;
      else
        s2_old_d = mem_q[s1_addr_q];
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (in_range(rd_addr_i)) begin
      if (commit_en && s2_addr_q == rd_addr_i)
        rd_data_d = mem_wr_d;
      else
        rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      s1_init_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_din_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_init_q  <= 1'b0;
      s2_addr_q  <= '0;
      s2_din_q   <= '0;
      s2_old_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_vld_q   <= acc_fire;
      s2_vld_q   <= s1_vld_q;
      rd_valid_q <= rd_fire;
      if (acc_fire) begin
        s1_init_q <= acc_init_i;
        s1_addr_q <= acc_addr_i;
        s1_din_q  <= SW'(acc_din_i);
      end
      if (s1_vld_q) begin
        s2_init_q <= s1_init_q;
        s2_addr_q <= s1_addr_q;
        s2_din_q  <= s1_din_q;
        s2_old_q  <= s2_old_d;
      end
      if (rd_fire)
        rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SCRATCH_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < SCRATCH_DEPTH; i++) begin
        if (state_q == CLEAR && cnt_q == AW'(i))
          mem_q[i] <= '0;
        else if (rd_clr_en && rd_addr_i == AW'(i))
          mem_q[i] <= '0;
        else if (commit_en && s2_addr_q == AW'(i))
          mem_q[i] <= mem_wr_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (clr_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_p_sum_accum_scratch.sv
// Bench for p_sum_accum_scratch: directed cases then random traffic against a delayed-apply array model.
module tb_p_sum_accum_scratch;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int IW = 16;
  localparam int SW = 24;
  localparam longint SMAX = 64'sd8388607;
  localparam longint SMIN = -64'sd8388608;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          acc_valid = 1'b0, acc_init = 1'b0, rd_en = 1'b0, rd_clear = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] acc_addr = '0, rd_addr = '0;
  logic [IW-1:0] acc_din = '0;
  logic          acc_ready, rd_valid, busy;
  logic [SW-1:0] rd_data;
`ifdef PSUM_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  p_sum_accum_scratch #(.ADDR_LEN(AW), .SCRATCH_DEPTH(D), .IN_WIDTH(IW), .SCRATCH_WIDTH(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_init_i(acc_init),
    .acc_addr_i(acc_addr), .acc_din_i(acc_din),
    .rd_en_i(rd_en), .rd_clear_i(rd_clear), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .clr_start_i(clr_start), .busy_o(busy)
`ifdef PSUM_SAT_EN
    , .sat_flag_o(sat_flag)
`endif
  );

  typedef struct {
    bit     v;
    bit     init;
    int     a;
    longint d;
  } op_t;

  int     n_chk = 0;
  int     n_fail = 0;
  longint model [D];
  bit     sat_exp = 1'b0;
  op_t    op1, op2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) model[i] = 0;
    sat_exp = 1'b0;
    op1 = '{v: 1'b0, init: 1'b0, a: 0, d: 0};
    op2 = op1;
  endtask

  // Sequential semantics: entry = din (init) or entry + din, saturating or wrapping at SW bits.
  task automatic apply_op(input op_t o);
    longint s;
    logic signed [SW-1:0] t;
    if (!o.v || o.a >= D) return;
    s = o.init ? o.d : model[o.a] + o.d;
`ifdef PSUM_SAT_EN
    if (!o.init && s > SMAX) begin s = SMAX; sat_exp = 1'b1; end
    if (!o.init && s < SMIN) begin s = SMIN; sat_exp = 1'b1; end
`endif
    t = s[SW-1:0];
    model[o.a] = t;
  endtask

  // One idle-state cycle; a read at cycle T observes every op accepted at T-2 or earlier.
  task automatic cyc(input bit av, input bit ai, input int aa, input int ad,
                     input bit re, input bit rc, input int ra);
    longint m;
    logic [SW-1:0] e;
    acc_valid = av; acc_init = ai; acc_addr = aa[AW-1:0]; acc_din = ad[IW-1:0];
    rd_en = re; rd_clear = rc; rd_addr = ra[AW-1:0]; clr_start = 1'b0;
    #1;
    chk("acc_ready_idle", acc_ready, 1);
    apply_op(op2);
    e = '0;
    if (re) begin
      m = model[ra];
      e = m[SW-1:0];
      if (rc) model[ra] = 0;
    end
    op2 = op1;
    op1 = '{v: av, init: ai, a: aa, d: longint'(ad)};
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, re);
    if (re) chk("rd_data_model", rd_data, e);
    chk("busy_idle", busy, 0);
`ifdef PSUM_SAT_EN
    chk("sat_flag_model", sat_flag, sat_exp);
`endif
  endtask

  task automatic idle_inputs();
    acc_valid = 1'b0; rd_en = 1'b0; rd_clear = 1'b0; clr_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_acc_ready", acc_ready, 1);
`ifdef PSUM_SAT_EN
    chk("rst_sat", sat_flag, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < D; i++) begin
      cyc(0, 0, 0, 0, 1, 0, i);
      chk("t1_zero", rd_data, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(1, 1, 2, 5, 0, 0, 0);
    cyc(1, 0, 2, -3, 0, 0, 0);
    cyc(1, 0, 2, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 2);
    chk("t2_chain", rd_data, 9);

    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 2, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("t3_addr1", rd_data, 2);
    cyc(0, 0, 0, 0, 1, 0, 2);
    chk("t3_addr2", rd_data, 2);

    cyc(1, 1, 3, 10, 0, 0, 0);
    cyc(1, 0, 3, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 3);
    chk("t4_commit_read", rd_data, 10);
    cyc(0, 0, 0, 0, 1, 1, 3);
    chk("t4_after_clear_fwd", rd_data, 4);
    cyc(0, 0, 0, 0, 1, 0, 3);
    chk("t4_cleared", rd_data, 0);

    for (int i = 0; i < D; i++) cyc(1, 1, i, i * 100 + 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 9);
    chk("t5_fill", rd_data, 901);
    cyc(1, 0, 7, 1, 0, 0, 0);
    acc_valid = 1'b1; acc_init = 1'b1; acc_addr = 4'd5; acc_din = 16'd77;
    rd_en = 1'b1; rd_clear = 1'b0; rd_addr = 4'd0; clr_start = 1'b1;
    #1;
    chk("t5_acc_ready_clr", acc_ready, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("t5_rd_rejected", rd_valid, 0);
    nb = 0;
    while (busy === 1'b1 && nb < 100) begin
      if (nb == 3) chk("t5_busy_acc_ready", acc_ready, 0);
      nb++;
      @(posedge clk);
      #1;
    end
    // One accumulate in flight leaves 2 drain cycles ahead of the 16 clear cycles.
    chk("t5_busy_cycles", nb, 18);
    model_reset();
    for (int i = 0; i < D; i++) begin
      cyc(0, 0, 0, 0, 1, 0, i);
      chk("t5_zero", rd_data, 0);
    end

    cyc(1, 1, 4, 32767, 0, 0, 0);
    for (int i = 0; i < 255; i++) cyc(1, 0, 4, 32767, 0, 0, 0);
    cyc(1, 0, 4, 248, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4);
    chk("t6_pre", rd_data, 8388600);
    cyc(1, 0, 4, 100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4);
`ifdef PSUM_SAT_EN
    chk("t6_sat_value", rd_data, 24'h7FFFFF);
    chk("t6_sat_flag", sat_flag, 1);
`else
    chk("t6_wrap_value", rd_data, 24'h80005C);
`endif

    for (int k = 0; k < 400; k++) begin
      d = int'($signed(16'($urandom)));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, D - 1)), d,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, D - 1)));
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, i);

    cyc(1, 1, 6, 55, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 6);
    chk("t7_pre", rd_data, 55);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t7_busy_mid_clear", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_rd_data", rd_data, 0);
    chk("t7_rst_rd_valid", rd_valid, 0);
    chk("t7_rst_acc_ready", acc_ready, 1);
`ifdef PSUM_SAT_EN
    chk("t7_rst_sat", sat_flag, 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 1, 0, 6);
    chk("t7_entry6_zero", rd_data, 0);
    cyc(0, 0, 0, 0, 1, 0, 4);
    chk("t7_entry4_zero", rd_data, 0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
